// File: rtl/mc_pkg.sv
// Shared types for the missionaries-and-cannibals engine: FSM states, rejection codes, count width.
// Pure declarations; no clocked logic lives here.
package mc_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_CAP    = 2'b01,
    ERR_SHORT  = 2'b10,
    ERR_UNSAFE = 2'b11
  } err_e;

  // Bits needed to hold 0..n people on one bank.
  function automatic int mc_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mc_rule_check.sv
// Combinational legality check of one crossing against the current banks; zero latency.
// No flow control: outputs follow inputs within the cycle.
module mc_rule_check
  import mc_pkg::*;
#(
  parameter  int N_PEOPLE = 3,
  parameter  int BOAT_CAP = 2,
  localparam int W        = mc_width(N_PEOPLE)
) (
  input  logic [W-1:0] bank_m,
  input  logic [W-1:0] bank_c,
  input  logic         boat_side,
  input  logic [W-1:0] mv_m,
  input  logic [W-1:0] mv_c,
  output logic         legal,
  output err_e         err_code,
  output logic [W-1:0] next_m,
  output logic [W-1:0] next_c
);

  int tot;
  int avail_m;
  int avail_c;
  int nm;
  int nc;
  int fm;
  int fc;

  always_comb begin
    tot     = int'(mv_m) + int'(mv_c);
    avail_m = boat_side ? (N_PEOPLE - int'(bank_m)) : int'(bank_m);
    avail_c = boat_side ? (N_PEOPLE - int'(bank_c)) : int'(bank_c);
    // Start-bank counts after the crossing; the far bank is the complement.
    nm      = boat_side ? (int'(bank_m) + int'(mv_m)) : (int'(bank_m) - int'(mv_m));
    nc      = boat_side ? (int'(bank_c) + int'(mv_c)) : (int'(bank_c) - int'(mv_c));
    fm      = N_PEOPLE - nm;
    fc      = N_PEOPLE - nc;

    err_code = ERR_NONE;
    if (tot == 0 || tot > BOAT_CAP) begin
      err_code = ERR_CAP;
    end else if (int'(mv_m) > avail_m || int'(mv_c) > avail_c) begin
      err_code = ERR_SHORT;
    end else if ((nm > 0 && nm < nc) || (fm > 0 && fm < fc)) begin
      err_code = ERR_UNSAFE;
    end

    legal  = (err_code == ERR_NONE);
    next_m = legal ? W'(nm) : bank_m;
    next_c = legal ? W'(nc) : bank_c;
  end

endmodule

// File: rtl/mc_river_engine.sv
// River-crossing game engine: a move accepted at E0 is judged at E1, results visible the cycle after E1.
// move_ready is high only in PLAY; CHECK and DONE refuse moves.
module mc_river_engine
  import mc_pkg::*;
#(
  parameter  int N_PEOPLE = 3,
  parameter  int BOAT_CAP = 2,
  parameter  int CNT_W    = 8,
  localparam int W        = mc_width(N_PEOPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [W-1:0]     move_m,
  input  logic [W-1:0]     move_c,
  output logic [W-1:0]     state_m,
  output logic [W-1:0]     state_c,
  output logic             boat_side,
  output logic             done,
  output logic             illegal,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] move_count
);

  localparam logic [W-1:0] FULL = W'(N_PEOPLE);

  state_e             fsm_q, fsm_d;
  logic [W-1:0]       bank_m_q, bank_m_d;
  logic [W-1:0]       bank_c_q, bank_c_d;
  logic [W-1:0]       mv_m_q, mv_m_d;
  logic [W-1:0]       mv_c_q, mv_c_d;
  logic               boat_q, boat_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  err_e               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               chk_legal;
  err_e               chk_err;
  logic [W-1:0]       chk_m;
  logic [W-1:0]       chk_c;

  mc_rule_check #(
    .N_PEOPLE (N_PEOPLE),
    .BOAT_CAP (BOAT_CAP)
  ) u_rule_check (
    .bank_m    (bank_m_q),
    .bank_c    (bank_c_q),
    .boat_side (boat_q),
    .mv_m      (mv_m_q),
    .mv_c      (mv_c_q),
    .legal     (chk_legal),
    .err_code  (chk_err),
    .next_m    (chk_m),
    .next_c    (chk_c)
  );

  always_comb begin
    fsm_d     = fsm_q;
    bank_m_d  = bank_m_q;
    bank_c_d  = bank_c_q;
    mv_m_d    = mv_m_q;
    mv_c_d    = mv_c_q;
    boat_d    = boat_q;
    ready_d   = ready_q;
    done_d    = done_q;
    illegal_d = 1'b0;
    err_d     = err_q;
    cnt_d     = cnt_q;

    if (restart) begin
      // A move offered alongside restart is dropped.
      fsm_d    = ST_PLAY;
      bank_m_d = FULL;
      bank_c_d = FULL;
      boat_d   = 1'b0;
      ready_d  = 1'b1;
      done_d   = 1'b0;
      err_d    = ERR_NONE;
      cnt_d    = '0;
    end else begin
      case (fsm_q)
        ST_PLAY: begin
          if (move_valid) begin
            mv_m_d  = move_m;
            mv_c_d  = move_c;
            err_d   = ERR_NONE;
            ready_d = 1'b0;
            fsm_d   = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_legal) begin
            bank_m_d = chk_m;
            bank_c_d = chk_c;
            boat_d   = ~boat_q;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (chk_m == '0 && chk_c == '0) begin
              fsm_d   = ST_DONE;
              done_d  = 1'b1;
              ready_d = 1'b0;
            end else begin
              fsm_d   = ST_PLAY;
              ready_d = 1'b1;
            end
          end else begin
            illegal_d = 1'b1;
            err_d     = chk_err;
            fsm_d     = ST_PLAY;
            ready_d   = 1'b1;
          end
        end
        default: begin
          fsm_d = ST_DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= ST_PLAY;
      bank_m_q  <= FULL;
      bank_c_q  <= FULL;
      mv_m_q    <= '0;
      mv_c_q    <= '0;
      boat_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      err_q     <= ERR_NONE;
      cnt_q     <= '0;
    end else begin
      fsm_q     <= fsm_d;
      bank_m_q  <= bank_m_d;
      bank_c_q  <= bank_c_d;
      mv_m_q    <= mv_m_d;
      mv_c_q    <= mv_c_d;
      boat_q    <= boat_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign move_ready = ready_q;
  assign state_m    = bank_m_q;
  assign state_c    = bank_c_q;
  assign boat_side  = boat_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign err_code   = err_q;
  assign move_count = cnt_q;

endmodule

// File: doc/mc_river_engine.md
MC_RIVER_ENGINE -- requirements
Module: mc_river_engine

Interface
REQ-001 SHALL have parameter N_PEOPLE, default 3; missionaries per side and cannibals per side (range 1..15).
REQ-002 SHALL have parameter BOAT_CAP, default 2; maximum number of people per crossing (range 1..N_PEOPLE).
REQ-003 SHALL have parameter CNT_W, default 8; width of the move counter.
REQ-004 SHALL define derived width W = clog2(N_PEOPLE+1).
REQ-005 SHALL have port clk, input, 1 bit; the single clock. Everything is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit; the reset is synchronous and active-high.
REQ-007 SHALL have port restart, input, 1 bit; synchronous game restart.
REQ-008 SHALL have port move_valid, input, 1 bit; a proposed crossing is present.
REQ-009 SHALL have port move_ready, output, 1 bit; the engine accepts a move this cycle.
REQ-010 SHALL have ports move_m and move_c, input, W bits each; missionaries and cannibals in the boat.
REQ-011 SHALL have ports state_m and state_c, output, W bits each; missionaries and cannibals on the start bank.
REQ-012 SHALL have port boat_side, output, 1 bit; 0 = start bank, 1 = far bank.
REQ-013 SHALL have port done, output, 1 bit; the puzzle is solved.
REQ-014 SHALL have port illegal, output, 1 bit; one-cycle pulse marking a rejected move.
REQ-015 SHALL have port err_code, output, 2 bits; cause of the last rejection.
REQ-016 SHALL have port move_count, output, CNT_W bits; number of legal moves applied.

Function
REQ-017 SHALL implement FSM states PLAY, CHECK and DONE; move_ready = 1 only in PLAY.
REQ-018 SHALL, on the edge where move_valid and move_ready are both 1 (edge E0):
- capture move_m and move_c;
- clear err_code;
- go to CHECK.
REQ-019 SHALL, at the next edge E1, evaluate the move against the state held since E0, then:
- legal move: update the state and go to PLAY, or to DONE if the new state is solved;
- illegal move: leave the state unchanged, pulse illegal for the cycle after E1, set err_code, and return to PLAY.
REQ-020 SHALL treat a move as a capacity error (err 01) when m+c = 0 or m+c > BOAT_CAP.
REQ-021 SHALL treat a move as an insufficient-people error (err 10) when the bank the boat is on holds fewer people of either kind than requested:
- start bank holds state_m / state_c;
- far bank holds N_PEOPLE-state_m / N_PEOPLE-state_c.
REQ-022 SHALL treat a move as an unsafe error (err 11) when, after the move, either bank has missionaries > 0 and missionaries < cannibals.
REQ-023 SHALL resolve multiple errors with priority 01 > 10 > 11.
REQ-024 SHALL apply a legal move as follows:
- subtract from the start bank when boat_side = 0, add to it when boat_side = 1;
- toggle boat_side;
- increment move_count, saturating at 2^CNT_W-1.
REQ-025 SHALL declare the game solved when state_m = 0 and state_c = 0; done is registered and asserts in the cycle after E1.
REQ-026 SHALL, in DONE, hold all outputs, keep done = 1 and move_ready = 0, and ignore move_valid.
REQ-027 SHALL, on restart = 1 in any state, on the next edge:
- set state_m = state_c = N_PEOPLE, boat_side = 0, move_count = 0, err_code = 0;
- clear illegal and done;
- enter PLAY.
REQ-028 SHALL give restart priority over move acceptance in the same cycle; the move is dropped.
REQ-029 SHALL keep illegal at 0 except for the single pulse cycle, and hold err_code until the next accepted move or restart.

Reset
REQ-030 SHALL, on reset = 1 at a clock edge, produce the REQ-027 values with move_ready = 1, regardless of FSM state.
REQ-031 SHALL give reset priority over restart and over move handling; a reset in CHECK discards the pending move.

Structure
REQ-032 SHALL place the FSM state enum, the err_code constants (NONE=00, CAP=01, SHORT=10, UNSAFE=11) and the W width function in a shared package mc_pkg.
REQ-033 SHALL implement legality checking as one combinational sub-module, mc_rule_check:
- inputs: bank counts, boat_side, move;
- outputs: legal flag, err_code, next bank counts.
REQ-034 SHALL keep all state registers in mc_river_engine.

Verification
REQ-035 SHALL cover reset: N=3 → state 3/3, boat_side 0, move_count 0, move_ready 1, done 0, err_code 0.
REQ-036 SHALL cover the full solution with N=3, CAP=2. Moves (m,c): (0,2) (0,1) (0,2) (0,1) (2,0) (1,1) (2,0) (0,1) (0,2) (0,1) (0,2). Required response: done = 1, move_count = 11, state 0/0, boat_side 1, illegal never asserted.
REQ-037 SHALL cover capacity errors from the initial state:
- move (2,1) → illegal pulse, err 01, state 3/3, move_count 0;
- move (0,0) → err 01.
REQ-038 SHALL cover safety and supply errors:
- from the initial state, move (1,0) → err 11, state unchanged;
- after legal move (0,2), return move (1,0) → err 10.
REQ-039 SHALL cover restart and reset ordering:
- restart together with move_valid in PLAY → move dropped, state 3/3;
- reset asserted in CHECK → initial state, move_count 0, no illegal pulse.
REQ-040 SHALL cover a parameter sweep with N=5, CAP=3: move (0,3) is legal, giving state 5/2; move (2,2) from the initial state gives err 01.
